cgra_io_sequencer: RTL and testbench
====================================

Name: cgra_io_sequencer

Overview:
- Execution sequencer directly upstream and downstream of the 6x6 torus PE array.
- On Start, steps through a per-cycle address buffer and reads two input buffers to drive Data0_Load and Data1_Load.
- Writes Data0_Store and Data1_Store into two output buffers and holds PE_Array_Busy high for exactly Exec_Cycles contiguous cycles.
- Pulses Done when the run completes.

Parameters:
- DWIDTH, 32, array data width; matches the array's SYS_DWIDTH.
- BUF_AW, 8, address width of each input/output data buffer.
- ABUF_AW, 10, address width of the per-step address buffer; max run = 2^ABUF_AW steps.
- AWORD_W, 4*BUF_AW+2, address-buffer word width; derived, not overridable.

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle run request; ignored unless IDLE.
- Exec_Cycles  in  ABUF_AW+1  step count; sampled on accepted Start.
- Done  out  1  one-cycle pulse at run end.
- Seq_Busy  out  1  high from accepted Start until Done, inclusive.
- ABuf_Addr  out  ABUF_AW  address-buffer read address; synchronous ROM, 1-cycle latency.
- ABuf_Data  in  AWORD_W  step word {Out1_We, Out1_Addr, Out0_We, Out0_Addr, In1_Addr, In0_Addr}, In0_Addr in the LSBs.
- IBuf0_Addr, IBuf1_Addr  out  BUF_AW  input-buffer read addresses; 1-cycle read latency.
- IBuf0_Data, IBuf1_Data  in  DWIDTH  input-buffer read data.
- OBuf0_Addr, OBuf1_Addr  out  BUF_AW  output-buffer write addresses.
- OBuf0_We, OBuf1_We  out  1  output-buffer write enables.
- OBuf0_Data, OBuf1_Data  out  DWIDTH  output-buffer write data.
- Data0_Load, Data1_Load  out  DWIDTH  to array PEIO loads; registered.
- Data0_Store, Data1_Store  in  DWIDTH  from array PEIO stores.
- PE_Array_Busy  out  1  array execute enable; registered.

Behaviour:
- Reset: every output 0; FSM to IDLE; all counters and pipeline registers cleared. Reset mid-run aborts immediately, issues no further writes and no Done.
- States: IDLE -> FILL -> RUN -> DONE -> IDLE.
- Start in IDLE, N = Exec_Cycles:
  - N = 0: go to DONE; Done is high the next cycle; PE_Array_Busy never rises.
  - N > 2^ABUF_AW: clamp N to 2^ABUF_AW.
  - Otherwise: go to FILL; the issue counter k=0 drives ABuf_Addr.
- Pipeline per step k, with accepted Start at cycle T:
  - Cycle T+1+k: ABuf_Addr = k.
  - Cycle T+2+k: ABuf_Data valid; IBuf0_Addr/IBuf1_Addr = In0_Addr/In1_Addr; store fields registered.
  - Cycle T+3+k: IBuf data valid; registered.
  - Cycle T+4+k: Data*_Load = step-k data, PE_Array_Busy = 1, OBuf*_Addr/We = step-k store fields, OBuf*_Data = Data*_Store (combinational pass-through).
- Address issue stops after k = N-1; the remaining stages drain.
- PE_Array_Busy is high for exactly N cycles, T+4 .. T+3+N. Data*_Load is 0 and OBuf*_We is 0 outside this window.
- FILL covers cycles T+1..T+3. RUN covers the busy window. DONE is cycle T+4+N: Done=1, Seq_Busy still 1. Return to IDLE the next cycle.
- Start asserted while not IDLE is ignored, with no queueing.
- The issue counter saturates at N; it never wraps ABuf_Addr within a run.
- Both OBuf ports may write the same address in the same step; OBuf1 has priority. The sequencer does not resolve this: it simply asserts both enables, and the buffer wrapper applies the priority.

Decomposition:
- cgra_io_pkg holds:
  - state enum (IDLE, FILL, RUN, DONE);
  - step-word field offsets/widths;
  - the constant PIPE_LAT = 3 (cycles from ABuf read to load presentation).
- One sub-module, cgra_step_pipe: the valid/store-field delay line (valid bit plus 2*(BUF_AW+1) store bits across stages). The FSM and counters stay in the top.

Test Plan:
- Start with Exec_Cycles=4; ABuf[0..3] In0=In1=0..3; IBuf0[i]=0x100+i, IBuf1[i]=0x200+i -> PE_Array_Busy high cycles T+4..T+7; Data0_Load = 0x100..0x103; Data1_Load = 0x200..0x203; Done at T+8.
- Same run with ABuf[2] Out0_We=1, Out0_Addr=0x05 and Data0_Store=0xDEADBEEF at T+6 -> exactly one OBuf0 write, addr 0x05, data 0xDEADBEEF, at T+6.
- Exec_Cycles=0 -> Done at T+1; PE_Array_Busy, OBuf*_We and Data*_Load stay 0.
- Exec_Cycles=2047 with ABUF_AW=10 -> clamped to 1024 busy cycles; ABuf_Addr never exceeds 1023.
- Start re-pulsed at T+5 during a 10-step run -> ignored; single Done at T+14.
- Reset asserted at T+6 of an 8-step run -> all outputs 0 asynchronously; no Done; a fresh Start then runs normally.

Source files
------------

// File: rtl/cgra_io_pkg.sv
// cgra_io_pkg
//   Shared definitions for the CGRA I/O sequencer:
//   - sequencer FSM state encoding
//   - step-word layout helpers (field offsets/widths as functions of BUF_AW)
//   - PIPE_LAT: cycles from address-buffer read to load presentation
//
// Step word layout (In0_Addr in the LSBs):
//   {Out1_We, Out1_Addr, Out0_We, Out0_Addr, In1_Addr, In0_Addr}
// The upper "store" slice {Out1_We, Out1_Addr, Out0_We, Out0_Addr}
// travels down the step pipeline; inside that slice:
//   [aw-1:0]     Out0_Addr
//   [aw]         Out0_We
//   [2aw:aw+1]   Out1_Addr
//   [2aw+1]      Out1_We
package cgra_io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

   localparam int PIPE_LAT = 3;

   function automatic int aword_w(input int buf_aw);
      return 4 * buf_aw + 2;
   endfunction

   function automatic int in1_lsb(input int buf_aw);
      return buf_aw;
   endfunction

   function automatic int store_lsb(input int buf_aw);
      return 2 * buf_aw;
   endfunction

   function automatic int store_w(input int buf_aw);
      return 2 * buf_aw + 2;
   endfunction

endpackage

// File: rtl/cgra_step_pipe.sv
// cgra_step_pipe
//   Valid / store-field delay line behind the address buffer.
//   Stage 0 (o_vld[0]): step word is on ABuf_Data (input-buffer addresses issued).
//   Stage 1 (o_vld[1]): input-buffer data valid; store fields captured.
//   Stage 2 (o_vld[2]): loads presented, array busy, output-buffer write.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_issue_v      an address-buffer read is being issued this cycle
//   i_store        store slice of the step word (valid when o_vld[0])
//   o_vld          per-stage valid bits
//   o_store        store slice aligned with o_vld[PIPE_LAT-1]; 0 when invalid
module cgra_step_pipe
   import cgra_io_pkg::*;
#(
   parameter int SW = 18
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_issue_v,
   input  logic [SW-1:0]       i_store,
   output logic [PIPE_LAT-1:0] o_vld,
   output logic [SW-1:0]       o_store
);

   logic [PIPE_LAT-1:0] r_vld;
   logic [SW-1:0]       r_store_b;
   logic [SW-1:0]       r_store_c;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vld     <= '0;
         r_store_b <= '0;
         r_store_c <= '0;
      end else begin
         r_vld     <= {r_vld[PIPE_LAT-2:0], i_issue_v};
         // Zero the fields of bubbles so no stale write enable can leak out.
         r_store_b <= r_vld[0] ? i_store : '0;
         r_store_c <= r_store_b;
      end
   end

   assign o_vld   = r_vld;
   assign o_store = r_store_c;

endmodule

// File: rtl/cgra_io_sequencer.sv
// cgra_io_sequencer
//   Execution sequencer around the 6x6 torus PE array. On an accepted
//   Start it walks the per-step address buffer for N = Exec_Cycles steps
//   (clamped to 2^ABUF_AW), reads the input buffers into Data0/1_Load,
//   writes Data0/1_Store into the output buffers, holds PE_Array_Busy for
//   exactly N contiguous cycles and pulses Done one cycle after that.
//
// Ports:
//   Clk, Reset                      clock, asynchronous active-high reset
//   Start, Exec_Cycles              run request (IDLE only) and step count
//   Done, Seq_Busy                  end-of-run pulse, run-in-progress flag
//   ABuf_Addr / ABuf_Data           address-buffer ROM (1-cycle latency)
//   IBuf0/1_Addr / IBuf0/1_Data     input buffers (1-cycle latency)
//   OBuf0/1_Addr/_We/_Data          output-buffer write ports
//   Data0/1_Load, Data0/1_Store     array PEIO load/store data
//   PE_Array_Busy                   array execute enable
module cgra_io_sequencer
   import cgra_io_pkg::*;
#(
   parameter  int DWIDTH  = 32,
   parameter  int BUF_AW  = 8,
   parameter  int ABUF_AW = 10,
   localparam int AWORD_W = 4 * BUF_AW + 2
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [ABUF_AW:0]   Exec_Cycles,
   output logic               Done,
   output logic               Seq_Busy,
   output logic [ABUF_AW-1:0] ABuf_Addr,
   input  logic [AWORD_W-1:0] ABuf_Data,
   output logic [BUF_AW-1:0]  IBuf0_Addr,
   output logic [BUF_AW-1:0]  IBuf1_Addr,
   input  logic [DWIDTH-1:0]  IBuf0_Data,
   input  logic [DWIDTH-1:0]  IBuf1_Data,
   output logic [BUF_AW-1:0]  OBuf0_Addr,
   output logic [BUF_AW-1:0]  OBuf1_Addr,
   output logic               OBuf0_We,
   output logic               OBuf1_We,
   output logic [DWIDTH-1:0]  OBuf0_Data,
   output logic [DWIDTH-1:0]  OBuf1_Data,
   output logic [DWIDTH-1:0]  Data0_Load,
   output logic [DWIDTH-1:0]  Data1_Load,
   input  logic [DWIDTH-1:0]  Data0_Store,
   input  logic [DWIDTH-1:0]  Data1_Store,
   output logic               PE_Array_Busy
);

   localparam int SW  = store_w(BUF_AW);
   localparam int SL  = store_lsb(BUF_AW);
   localparam int I1L = in1_lsb(BUF_AW);
   localparam logic [ABUF_AW:0] MAX_N = {1'b1, {ABUF_AW{1'b0}}};

   seq_state_e          r_state;
   seq_state_e          w_state_nxt;
   logic [ABUF_AW:0]    r_n;
   logic [ABUF_AW:0]    r_issue;
   logic                w_issue_v;
   logic                w_accept;
   logic [PIPE_LAT-1:0] w_vld;
   logic [SW-1:0]       w_store_c;
   logic [DWIDTH-1:0]   r_load0;
   logic [DWIDTH-1:0]   r_load1;

   assign w_accept  = Start && (r_state == ST_IDLE);
   // Issue counter saturates at N, so ABuf_Addr never wraps within a run.
   assign w_issue_v = ((r_state == ST_FILL) || (r_state == ST_RUN)) && (r_issue < r_n);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_n     <= '0;
         r_issue <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_n     <= (Exec_Cycles > MAX_N) ? MAX_N : Exec_Cycles;
            r_issue <= '0;
         end else if (w_issue_v) begin
            r_issue <= r_issue + 1'b1;
         end
      end
   end

   // FILL ends when step 0 reaches the input-buffer data stage; RUN ends the
   // first cycle that stage is empty, which closes the busy window after N.
   always_comb begin
      w_state_nxt = r_state;
      Done        = 1'b0;
      Seq_Busy    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            Seq_Busy = 1'b0;
            if (Start) w_state_nxt = (Exec_Cycles == '0) ? ST_DONE : ST_FILL;
         end
         ST_FILL: if (w_vld[1])  w_state_nxt = ST_RUN;
         ST_RUN:  if (!w_vld[1]) w_state_nxt = ST_DONE;
         ST_DONE: begin
            Done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   cgra_step_pipe #(
      .SW (SW)
   ) u_step_pipe (
      .i_clk     (Clk),
      .i_rst     (Reset),
      .i_issue_v (w_issue_v),
      .i_store   (ABuf_Data[AWORD_W-1:SL]),
      .o_vld     (w_vld),
      .o_store   (w_store_c)
   );

   assign ABuf_Addr  = w_issue_v ? r_issue[ABUF_AW-1:0] : '0;
   assign IBuf0_Addr = w_vld[0] ? ABuf_Data[BUF_AW-1:0] : '0;
   assign IBuf1_Addr = w_vld[0] ? ABuf_Data[I1L+BUF_AW-1:I1L] : '0;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_load0 <= '0;
         r_load1 <= '0;
      end else begin
         r_load0 <= w_vld[1] ? IBuf0_Data : '0;
         r_load1 <= w_vld[1] ? IBuf1_Data : '0;
      end
   end

   assign Data0_Load    = r_load0;
   assign Data1_Load    = r_load1;
   assign PE_Array_Busy = w_vld[PIPE_LAT-1];

   // Same-address writes on both ports are passed through untouched; the
   // buffer wrapper gives OBuf1 priority.
   assign OBuf0_Addr = w_store_c[BUF_AW-1:0];
   assign OBuf0_We   = w_vld[PIPE_LAT-1] & w_store_c[BUF_AW];
   assign OBuf1_Addr = w_store_c[2*BUF_AW:BUF_AW+1];
   assign OBuf1_We   = w_vld[PIPE_LAT-1] & w_store_c[2*BUF_AW+1];
   assign OBuf0_Data = w_vld[PIPE_LAT-1] ? Data0_Store : '0;
   assign OBuf1_Data = w_vld[PIPE_LAT-1] ? Data1_Store : '0;

endmodule

// File: tb/tb_cgra_io_sequencer.sv
// tb_cgra_io_sequencer
//   Directed bench for cgra_io_sequencer. Address and input buffers are
//   modelled as 1-cycle-latency memories. Inputs are driven just after the
//   falling edge; outputs are sampled 1 time unit later. "c" is the cycle
//   offset from the cycle T in which Start was presented.
module tb_cgra_io_sequencer;

   localparam int DW  = 32;
   localparam int BAW = 8;
   localparam int AAW = 10;
   localparam int AWW = 4 * BAW + 2;

   logic           Clk;
   logic           Reset;
   logic           Start;
   logic [AAW:0]   Exec_Cycles;
   logic           Done;
   logic           Seq_Busy;
   logic [AAW-1:0] ABuf_Addr;
   logic [AWW-1:0] ABuf_Data;
   logic [BAW-1:0] IBuf0_Addr, IBuf1_Addr;
   logic [DW-1:0]  IBuf0_Data, IBuf1_Data;
   logic [BAW-1:0] OBuf0_Addr, OBuf1_Addr;
   logic           OBuf0_We, OBuf1_We;
   logic [DW-1:0]  OBuf0_Data, OBuf1_Data;
   logic [DW-1:0]  Data0_Load, Data1_Load;
   logic [DW-1:0]  Data0_Store, Data1_Store;
   logic           PE_Array_Busy;

   cgra_io_sequencer #(
      .DWIDTH  (DW),
      .BUF_AW  (BAW),
      .ABUF_AW (AAW)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Start         (Start),
      .Exec_Cycles   (Exec_Cycles),
      .Done          (Done),
      .Seq_Busy      (Seq_Busy),
      .ABuf_Addr     (ABuf_Addr),
      .ABuf_Data     (ABuf_Data),
      .IBuf0_Addr    (IBuf0_Addr),
      .IBuf1_Addr    (IBuf1_Addr),
      .IBuf0_Data    (IBuf0_Data),
      .IBuf1_Data    (IBuf1_Data),
      .OBuf0_Addr    (OBuf0_Addr),
      .OBuf1_Addr    (OBuf1_Addr),
      .OBuf0_We      (OBuf0_We),
      .OBuf1_We      (OBuf1_We),
      .OBuf0_Data    (OBuf0_Data),
      .OBuf1_Data    (OBuf1_Data),
      .Data0_Load    (Data0_Load),
      .Data1_Load    (Data1_Load),
      .Data0_Store   (Data0_Store),
      .Data1_Store   (Data1_Store),
      .PE_Array_Busy (PE_Array_Busy)
   );

   // ---------------- clock ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- buffer models ----------------
   logic [AWW-1:0] abuf_mem  [0:(1<<AAW)-1];
   logic [DW-1:0]  ibuf0_mem [0:(1<<BAW)-1];
   logic [DW-1:0]  ibuf1_mem [0:(1<<BAW)-1];

   always @(posedge Clk) begin
      ABuf_Data  <= abuf_mem[ABuf_Addr];
      IBuf0_Data <= ibuf0_mem[IBuf0_Addr];
      IBuf1_Data <= ibuf1_mem[IBuf1_Addr];
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"},   {Done, Seq_Busy, PE_Array_Busy, OBuf0_We, OBuf1_We}, 64'd0);
      chk({tag, "_addr"},  {ABuf_Addr, IBuf0_Addr, IBuf1_Addr, OBuf0_Addr, OBuf1_Addr}, 64'd0);
      chk({tag, "_load"},  {Data0_Load, Data1_Load}, 64'd0);
      chk({tag, "_odata"}, {OBuf0_Data, OBuf1_Data}, 64'd0);
   endtask

   // Present Start for one cycle (cycle T); the caller's loop clears it.
   task automatic start_run(input int n);
      @(negedge Clk);
      Start       = 1'b1;
      Exec_Cycles = n[AAW:0];
   endtask

   // ---------------- stimulus ----------------
   logic [DW-1:0] exp_d;
   int busy_cnt, done_cnt, done_c, max_addr;
   logic busy_e;

   initial begin
      Reset       = 1'b1;
      Start       = 1'b0;
      Exec_Cycles = '0;
      Data0_Store = '0;
      Data1_Store = '0;
      for (int i = 0; i < (1 << AAW); i++) begin
         abuf_mem[i] = '0;
         abuf_mem[i][7:0]  = i[7:0];
         abuf_mem[i][15:8] = i[7:0];
      end
      for (int i = 0; i < (1 << BAW); i++) begin
         ibuf0_mem[i] = 32'h100 + i;
         ibuf1_mem[i] = 32'h200 + i;
      end

      // Reset state
      repeat (2) @(negedge Clk);
      #1;
      chk_all_zero("reset");
      Reset = 1'b0;

      // Test 1: basic 4-step run
      start_run(4);
      for (int c = 1; c <= 9; c++) begin
         @(negedge Clk);
         Start = 1'b0;
         #1;
         busy_e = (c >= 4) && (c <= 7);
         chk("t1_busy", PE_Array_Busy, busy_e);
         exp_d = busy_e ? (32'h100 + 32'(c - 4)) : 32'h0;
         chk("t1_load0", Data0_Load, exp_d);
         exp_d = busy_e ? (32'h200 + 32'(c - 4)) : 32'h0;
         chk("t1_load1", Data1_Load, exp_d);
         chk("t1_done", Done, c == 8);
         chk("t1_seq_busy", Seq_Busy, c <= 8);
         chk("t1_obuf_we", {OBuf0_We, OBuf1_We}, 64'd0);
         if (c <= 4) chk("t1_abuf_addr", ABuf_Addr, 64'(c - 1));
         if (c >= 2 && c <= 5) chk("t1_ibuf_addr", {IBuf1_Addr, IBuf0_Addr}, {8'(c - 2), 8'(c - 2)});
      end

      // Test 2: step 2 writes OBuf0 address 0x05
      abuf_mem[2][24]    = 1'b1;
      abuf_mem[2][23:16] = 8'h05;
      start_run(4);
      for (int c = 1; c <= 9; c++) begin
         @(negedge Clk);
         Start       = 1'b0;
         Data0_Store = (c == 6) ? 32'hDEADBEEF : 32'h12345678;
         Data1_Store = 32'h0BAD0BAD;
         #1;
         chk("t2_obuf0_we", OBuf0_We, c == 6);
         chk("t2_obuf1_we", OBuf1_We, 1'b0);
         if (c == 6) begin
            chk("t2_obuf0_addr", OBuf0_Addr, 64'h05);
            chk("t2_obuf0_data", OBuf0_Data, 64'hDEADBEEF);
            chk("t2_load0", Data0_Load, 64'h102);
         end
         chk("t2_done", Done, c == 8);
      end
      abuf_mem[2][24:16] = '0;
      Data0_Store = '0;
      Data1_Store = '0;

      // Test 3: zero-length run
      start_run(0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge Clk);
         Start = 1'b0;
         #1;
         chk("t3_done", Done, c == 1);
         chk("t3_seq_busy", Seq_Busy, c == 1);
         chk("t3_busy", PE_Array_Busy, 1'b0);
         chk("t3_we", {OBuf0_We, OBuf1_We}, 64'd0);
         chk("t3_load", {Data0_Load, Data1_Load}, 64'd0);
      end

      // Test 4: oversize count clamps to 1024
      busy_cnt = 0;
      done_c   = -1;
      max_addr = 0;
      start_run(2047);
      for (int c = 1; c <= 1032; c++) begin
         @(negedge Clk);
         Start = 1'b0;
         #1;
         if (PE_Array_Busy) busy_cnt++;
         if (Done && done_c < 0) done_c = c;
         if (int'(ABuf_Addr) > max_addr) max_addr = int'(ABuf_Addr);
         if (c == 4)    chk("t4_first_busy", PE_Array_Busy, 1'b1);
         if (c == 1027) chk("t4_last_load0", Data0_Load, 64'h1FF);
      end
      chk("t4_busy_cnt", 64'(busy_cnt), 64'd1024);
      chk("t4_done_c", 64'(done_c), 64'd1028);
      chk("t4_max_addr", 64'(max_addr), 64'd1023);

      // Test 5: Start re-pulsed mid-run is ignored
      busy_cnt = 0;
      done_cnt = 0;
      done_c   = -1;
      start_run(10);
      for (int c = 1; c <= 16; c++) begin
         @(negedge Clk);
         Start       = (c == 5);
         Exec_Cycles = 11'd3;
         #1;
         if (PE_Array_Busy) busy_cnt++;
         if (Done) begin
            done_cnt++;
            done_c = c;
         end
         if (c >= 15) chk("t5_idle_after", Seq_Busy, 1'b0);
      end
      chk("t5_busy_cnt", 64'(busy_cnt), 64'd10);
      chk("t5_done_cnt", 64'(done_cnt), 64'd1);
      chk("t5_done_c", 64'(done_c), 64'd14);

      // Test 6: asynchronous reset mid-run, then a fresh run
      start_run(8);
      for (int c = 1; c <= 5; c++) begin
         @(negedge Clk);
         Start = 1'b0;
         #1;
      end
      chk("t6_busy_before", PE_Array_Busy, 1'b1);
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      chk_all_zero("t6_reset");
      @(negedge Clk);
      Reset = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge Clk);
         #1;
         if (Done || Seq_Busy || PE_Array_Busy || OBuf0_We || OBuf1_We) done_cnt++;
      end
      chk("t6_quiet_after", 64'(done_cnt), 64'd0);
      busy_cnt = 0;
      start_run(4);
      for (int c = 1; c <= 9; c++) begin
         @(negedge Clk);
         Start = 1'b0;
         #1;
         if (PE_Array_Busy) busy_cnt++;
         chk("t6_done", Done, c == 8);
         if (c == 4) chk("t6_load0", Data0_Load, 64'h100);
      end
      chk("t6_busy_cnt", 64'(busy_cnt), 64'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
